// File: rtl/axi_csr_burst_sub_if.sv
// rtl/axi_csr_burst_sub_if.sv - AXI burst subordinate bus bundle (AW/W/B/AR/R channels)
interface axi_csr_burst_sub_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0]   s_axi_awaddr;
  logic [7:0]              s_axi_awlen;
  logic                    s_axi_awvalid;
  logic                    s_axi_awready;
  logic [DATA_WIDTH-1:0]   s_axi_wdata;
  logic [DATA_WIDTH/8-1:0] s_axi_wstrb;
  logic                    s_axi_wlast;
  logic                    s_axi_wvalid;
  logic                    s_axi_wready;
  logic [1:0]              s_axi_bresp;
  logic                    s_axi_bvalid;
  logic                    s_axi_bready;
  logic [ADDR_WIDTH-1:0]   s_axi_araddr;
  logic [7:0]              s_axi_arlen;
  logic                    s_axi_arvalid;
  logic                    s_axi_arready;
  logic [DATA_WIDTH-1:0]   s_axi_rdata;
  logic [1:0]              s_axi_rresp;
  logic                    s_axi_rlast;
  logic                    s_axi_rvalid;
  logic                    s_axi_rready;

  modport slave (
    input  s_axi_awaddr, s_axi_awlen, s_axi_awvalid,
    output s_axi_awready,
    input  s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
    output s_axi_wready,
    output s_axi_bresp, s_axi_bvalid,
    input  s_axi_bready,
    input  s_axi_araddr, s_axi_arlen, s_axi_arvalid,
    output s_axi_arready,
    output s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
    input  s_axi_rready
  );

  modport master (
    output s_axi_awaddr, s_axi_awlen, s_axi_awvalid,
    input  s_axi_awready,
    output s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
    input  s_axi_wready,
    input  s_axi_bresp, s_axi_bvalid,
    output s_axi_bready,
    output s_axi_araddr, s_axi_arlen, s_axi_arvalid,
    input  s_axi_arready,
    input  s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
    output s_axi_rready
  );
endinterface

// File: rtl/axi_csr_burst_sub.sv
// rtl/axi_csr_burst_sub.sv - AXI INCR-burst subordinate with integrated CSR bank
// Optional: define AXI_SUB_DECERR_EN to answer out-of-range beats with DECERR instead of OKAY.
module axi_csr_burst_sub #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    NUM_REGS   = 16,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                           s_axi_clk,
  input  logic                           s_axi_reset,
  axi_csr_burst_sub_if.slave             bus,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]            reg_wr_pulse
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int SHIFT = $clog2(BYTES);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(BYTES);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
`ifdef AXI_SUB_DECERR_EN
  localparam logic [1:0] RESP_OOR    = 2'b11;
`else
  localparam logic [1:0] RESP_OOR    = RESP_OKAY;
`endif

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA} r_state_t;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic                  rst_done;

  w_state_t              w_state, w_next;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [7:0]            w_len, w_count;
  logic [1:0]            b_resp;
  logic                  aw_ready, w_ready, b_valid;
  logic                  w_count_hit, w_last_beat;
  logic [1:0]            w_beat_resp;

  r_state_t              r_state, r_next;
  logic [ADDR_WIDTH-1:0] r_addr, r_addr_next;
  logic [7:0]            r_len, r_count;
  logic [DATA_WIDTH-1:0] r_data;
  logic [1:0]            r_resp;
  logic                  r_last, ar_ready, r_valid;

  function automatic int reg_index(input logic [ADDR_WIDTH-1:0] a);
    return int'(a >> SHIFT);
  endfunction

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return reg_index(a) < NUM_REGS;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] read_word(input logic [ADDR_WIDTH-1:0] a);
    logic [DATA_WIDTH-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (reg_index(a) == i) v = regs[i];
    return v;
  endfunction

  function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  // Burst ends on wlast or the awlen+1'th beat; disagreement between the two is a length error.
  always_comb begin
    w_count_hit = (w_count == w_len);
    w_last_beat = bus.s_axi_wlast || w_count_hit;
    w_beat_resp = in_range(w_addr) ? RESP_OKAY : RESP_OOR;
    if (bus.s_axi_wlast != w_count_hit) w_beat_resp = worst(w_beat_resp, RESP_SLVERR);
  end

  always_comb begin
    w_next   = w_state;
    aw_ready = 1'b0;
    w_ready  = 1'b0;
    b_valid  = 1'b0;
    case (w_state)
      W_IDLE: begin
        aw_ready = rst_done;
        if (rst_done && bus.s_axi_awvalid) w_next = W_DATA;
      end
      W_DATA: begin
        w_ready = 1'b1;
        if (bus.s_axi_wvalid && w_last_beat) w_next = W_RESP;
      end
      W_RESP: begin
        b_valid = 1'b1;
        if (bus.s_axi_bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge s_axi_clk) begin
    if (s_axi_reset) begin
      rst_done     <= 1'b0;
      w_state      <= W_IDLE;
      w_addr       <= '0;
      w_len        <= '0;
      w_count      <= '0;
      b_resp       <= RESP_OKAY;
      reg_wr_pulse <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
    end else begin
      rst_done     <= 1'b1;
      w_state      <= w_next;
      reg_wr_pulse <= '0;
      if (aw_ready && bus.s_axi_awvalid) begin
        w_addr  <= bus.s_axi_awaddr;
        w_len   <= bus.s_axi_awlen;
        w_count <= '0;
        b_resp  <= RESP_OKAY;
      end
      if (w_ready && bus.s_axi_wvalid) begin
        w_addr  <= w_addr + ADDR_STEP;
        w_count <= w_count + 8'd1;
        b_resp  <= worst(b_resp, w_beat_resp);
        for (int i = 0; i < NUM_REGS; i++) begin
          if (reg_index(w_addr) == i) begin
            reg_wr_pulse[i] <= 1'b1;
            for (int b = 0; b < BYTES; b++)
              if (bus.s_axi_wstrb[b]) regs[i][b*8 +: 8] <= bus.s_axi_wdata[b*8 +: 8];
          end
        end
      end
    end
  end

  always_comb begin
    r_next      = r_state;
    ar_ready    = 1'b0;
    r_valid     = 1'b0;
    r_addr_next = r_addr + ADDR_STEP;
    case (r_state)
      R_IDLE: begin
        ar_ready = rst_done;
        if (rst_done && bus.s_axi_arvalid) r_next = R_DATA;
      end
      R_DATA: begin
        r_valid = 1'b1;
        if (bus.s_axi_rready && r_last) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  // Beat data is captured at the preceding handshake edge, so a same-edge write is not yet visible.
  always_ff @(posedge s_axi_clk) begin
    if (s_axi_reset) begin
      r_state <= R_IDLE;
      r_addr  <= '0;
      r_len   <= '0;
      r_count <= '0;
      r_data  <= '0;
      r_resp  <= RESP_OKAY;
      r_last  <= 1'b0;
    end else begin
      r_state <= r_next;
      if (ar_ready && bus.s_axi_arvalid) begin
        r_addr  <= bus.s_axi_araddr;
        r_len   <= bus.s_axi_arlen;
        r_count <= '0;
        r_data  <= read_word(bus.s_axi_araddr);
        r_resp  <= in_range(bus.s_axi_araddr) ? RESP_OKAY : RESP_OOR;
        r_last  <= (bus.s_axi_arlen == 8'd0);
      end else if (r_valid && bus.s_axi_rready && !r_last) begin
        r_addr  <= r_addr_next;
        r_count <= r_count + 8'd1;
        r_data  <= read_word(r_addr_next);
        r_resp  <= in_range(r_addr_next) ? RESP_OKAY : RESP_OOR;
        r_last  <= ((r_count + 8'd1) == r_len);
      end
    end
  end

  assign bus.s_axi_awready = aw_ready;
  assign bus.s_axi_wready  = w_ready;
  assign bus.s_axi_bvalid  = b_valid;
  assign bus.s_axi_bresp   = b_resp;
  assign bus.s_axi_arready = ar_ready;
  assign bus.s_axi_rvalid  = r_valid;
  assign bus.s_axi_rdata   = r_data;
  assign bus.s_axi_rresp   = r_resp;
  assign bus.s_axi_rlast   = r_last;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
  end
endmodule

// File: tb/tb_axi_csr_burst_sub.sv
// tb/tb_axi_csr_burst_sub.sv - randomized self-checking bench for axi_csr_burst_sub
module tb_axi_csr_burst_sub;
  localparam int          DW = 32;
  localparam int          AW = 8;
  localparam int          NR = 16;
  localparam logic [31:0] RV = 32'h1234_5678;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NR*DW-1:0] reg_out;
  logic [NR-1:0]  reg_wr_pulse;

  axi_csr_burst_sub_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  axi_csr_burst_sub #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR), .RESET_VAL(RV)) dut (
    .s_axi_clk(clk), .s_axi_reset(rst), .bus(bus.slave),
    .reg_out(reg_out), .reg_wr_pulse(reg_wr_pulse)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] mreg [NR];
  logic [31:0] wd [256];
  logic [3:0]  ws [256];
  bit          rdy_pat [$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] oor_resp();
`ifdef AXI_SUB_DECERR_EN
    return 2'b11;
`else
    return 2'b00;
`endif
  endfunction

  function automatic logic [1:0] max2(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  task automatic idle_inputs();
    bus.s_axi_awvalid = 0; bus.s_axi_wvalid = 0; bus.s_axi_wlast = 0; bus.s_axi_bready = 0;
    bus.s_axi_arvalid = 0; bus.s_axi_rready = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (3) @(negedge clk);
    for (int i = 0; i < NR; i++) mreg[i] = RV;
    check_eq("rst_awready", bus.s_axi_awready, 0);
    check_eq("rst_arready", bus.s_axi_arready, 0);
    check_eq("rst_wready", bus.s_axi_wready, 0);
    check_eq("rst_bvalid", bus.s_axi_bvalid, 0);
    check_eq("rst_bresp", bus.s_axi_bresp, 0);
    check_eq("rst_rvalid", bus.s_axi_rvalid, 0);
    check_eq("rst_rdata", bus.s_axi_rdata, 0);
    check_eq("rst_rresp_rlast", {bus.s_axi_rresp, bus.s_axi_rlast}, 0);
    check_eq("rst_pulse", reg_wr_pulse, 0);
    for (int i = 0; i < NR; i++) check_eq("rst_reg", reg_out[i*DW +: DW], RV);
    rst = 1'b0;
    check_eq("rel_awready_same", bus.s_axi_awready, 0);
    @(negedge clk);
    check_eq("rel_awready_next", bus.s_axi_awready, 1);
    check_eq("rel_arready_next", bus.s_axi_arready, 1);
  endtask

  task automatic aw_phase(input logic [7:0] addr, input logic [7:0] len);
    int n;
    bus.s_axi_awaddr = addr; bus.s_axi_awlen = len; bus.s_axi_awvalid = 1;
    n = 0;
    while (!bus.s_axi_awready && n < 20) begin @(negedge clk); n++; end
    check_eq("awready_wait", bus.s_axi_awready, 1);
    @(negedge clk);
    bus.s_axi_awvalid = 0;
    check_eq("wready_after_aw", bus.s_axi_wready, 1);
    check_eq("awready_busy", bus.s_axi_awready, 0);
  endtask

  // Applies one W beat to the model; returns that beat's address-derived response.
  task automatic model_beat(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp, output logic [NR-1:0] pulse);
    int idx;
    idx = int'(a) / 4;
    pulse = '0;
    resp = 2'b00;
    if (idx < NR) begin
      for (int b = 0; b < 4; b++) if (s[b]) mreg[idx][b*8 +: 8] = d[b*8 +: 8];
      pulse[idx] = 1'b1;
    end else begin
      resp = oor_resp();
    end
  endtask

  task automatic do_write(input logic [7:0] addr, input int len, input int nbeats, input bit last_flag);
    logic [1:0]    exp_resp, r;
    logic [NR-1:0] p;
    logic [7:0]    a;
    int            stall;
    aw_phase(addr, 8'(len));
    exp_resp = 2'b00;
    for (int i = 0; i < nbeats; i++) begin
      if ($urandom_range(0, 2) == 0) @(negedge clk);
      a = addr + 8'(4 * i);
      bus.s_axi_wdata = wd[i]; bus.s_axi_wstrb = ws[i];
      bus.s_axi_wlast = last_flag && (i == nbeats - 1);
      bus.s_axi_wvalid = 1;
      check_eq("wready_beat", bus.s_axi_wready, 1);
      @(negedge clk);
      bus.s_axi_wvalid = 0; bus.s_axi_wlast = 0;
      model_beat(a, wd[i], ws[i], r, p);
      exp_resp = max2(exp_resp, r);
      check_eq("wr_pulse", reg_wr_pulse, p);
      if (int'(a) / 4 < NR) check_eq("wr_reg", reg_out[(int'(a)/4)*DW +: DW], mreg[int'(a)/4]);
    end
    if (last_flag != (nbeats == len + 1)) exp_resp = max2(exp_resp, 2'b10);
    check_eq("bvalid_after_last", bus.s_axi_bvalid, 1);
    check_eq("bresp", bus.s_axi_bresp, exp_resp);
    stall = $urandom_range(0, 2);
    repeat (stall) begin
      @(negedge clk);
      check_eq("bresp_hold", {bus.s_axi_bvalid, bus.s_axi_bresp}, {1'b1, exp_resp});
    end
    bus.s_axi_bready = 1;
    @(negedge clk);
    bus.s_axi_bready = 0;
    check_eq("bvalid_clear", bus.s_axi_bvalid, 0);
    check_eq("awready_back", bus.s_axi_awready, 1);
    for (int i = 0; i < NR; i++) check_eq("post_wr_reg", reg_out[i*DW +: DW], mreg[i]);
  endtask

  task automatic do_read(input logic [7:0] addr, input int len);
    int          n, stalls, idx;
    bit          rdy;
    logic [7:0]  a;
    logic [31:0] ed;
    logic [1:0]  er;
    bus.s_axi_araddr = addr; bus.s_axi_arlen = 8'(len); bus.s_axi_arvalid = 1;
    n = 0;
    while (!bus.s_axi_arready && n < 20) begin @(negedge clk); n++; end
    check_eq("arready_wait", bus.s_axi_arready, 1);
    @(negedge clk);
    bus.s_axi_arvalid = 0;
    for (int b = 0; b <= len; b++) begin
      a = addr + 8'(4 * b);
      idx = int'(a) / 4;
      ed = (idx < NR) ? mreg[idx] : 32'h0;
      er = (idx < NR) ? 2'b00 : oor_resp();
      stalls = 0;
      forever begin
        check_eq("rvalid", bus.s_axi_rvalid, 1);
        check_eq("rdata", bus.s_axi_rdata, ed);
        check_eq("rresp", bus.s_axi_rresp, er);
        check_eq("rlast", bus.s_axi_rlast, b == len);
        if (rdy_pat.size() > 0) rdy = rdy_pat.pop_front();
        else rdy = ($urandom_range(0, 2) != 0) || (stalls >= 3);
        bus.s_axi_rready = rdy;
        @(negedge clk);
        if (rdy) break;
        stalls++;
      end
    end
    bus.s_axi_rready = 0;
    check_eq("rvalid_done", bus.s_axi_rvalid, 0);
    check_eq("arready_back", bus.s_axi_arready, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] oldv;
    int          a, ln, mode, nb;
    idle_inputs();
    bus.s_axi_awaddr = 0; bus.s_axi_awlen = 0; bus.s_axi_wdata = 0; bus.s_axi_wstrb = 0;
    bus.s_axi_araddr = 0; bus.s_axi_arlen = 0;
    do_reset();

    wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
    do_write(8'h08, 0, 1, 1);

    for (int i = 0; i < 4; i++) wd[i] = 32'(i + 1);
    ws[0] = 4'hF; ws[1] = 4'hF; ws[2] = 4'h3; ws[3] = 4'hF;
    do_write(8'h00, 3, 4, 1);

    rdy_pat = '{1, 0, 1, 1, 0, 1};
    do_read(8'h04, 3);

    do_read(8'h3C, 1);

    for (int i = 0; i < 4; i++) begin wd[i] = 32'hA000_0000 + 32'(i); ws[i] = 4'hF; end
    do_write(8'h10, 3, 2, 1);
    do_write(8'h20, 1, 2, 0);
    do_write(8'hFC, 1, 2, 1);

    for (int it = 0; it < 40; it++) begin
      a = $urandom_range(0, 80);
      ln = $urandom_range(0, 4);
      mode = $urandom_range(0, 5);
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 5; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
        if (mode == 0 && ln > 0) do_write(8'(a), ln, $urandom_range(1, ln), 1);
        else if (mode == 1) do_write(8'(a), ln, ln + 1, 0);
        else do_write(8'(a), ln, ln + 1, 1);
      end else begin
        do_read(8'(a), ln);
      end
    end

    oldv = mreg[5];
    aw_phase(8'h14, 8'd0);
    bus.s_axi_wdata = 32'h5555_AAAA; bus.s_axi_wstrb = 4'hF; bus.s_axi_wlast = 1; bus.s_axi_wvalid = 1;
    bus.s_axi_araddr = 8'h14; bus.s_axi_arlen = 8'd0; bus.s_axi_arvalid = 1;
    check_eq("conc_arready", bus.s_axi_arready, 1);
    @(negedge clk);
    bus.s_axi_wvalid = 0; bus.s_axi_wlast = 0; bus.s_axi_arvalid = 0;
    mreg[5] = 32'h5555_AAAA;
    check_eq("conc_rvalid", bus.s_axi_rvalid, 1);
    check_eq("conc_rdata_old", bus.s_axi_rdata, oldv);
    check_eq("conc_reg_new", reg_out[5*DW +: DW], 32'h5555_AAAA);
    check_eq("conc_bvalid", {bus.s_axi_bvalid, bus.s_axi_bresp}, 3'b100);
    bus.s_axi_rready = 1; bus.s_axi_bready = 1;
    @(negedge clk);
    bus.s_axi_rready = 0; bus.s_axi_bready = 0;

    aw_phase(8'h00, 8'd3);
    bus.s_axi_wdata = 32'hCAFE_F00D; bus.s_axi_wstrb = 4'hF; bus.s_axi_wvalid = 1;
    @(negedge clk);
    bus.s_axi_wvalid = 0;
    check_eq("pre_rst_reg0", reg_out[0 +: DW], 32'hCAFE_F00D);
    do_reset();
    check_eq("post_rst_bvalid", bus.s_axi_bvalid, 0);
    check_eq("post_rst_wready", bus.s_axi_wready, 0);

    wd[0] = 32'h0BAD_CAFE; ws[0] = 4'hC;
    do_write(8'h2C, 0, 1, 1);
    do_read(8'h28, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
